// File: rtl/dnn_param_loader_pkg.sv
// Shared types and memory-map defaults for the DNN parameter loader.
// Checksum states are present only when DNN_LOADER_CHECKSUM_EN is defined.
package dnn_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  localparam int          DEF_ADDR_WIDTH = 17;
  localparam int unsigned DEF_ADDR_BASE  = 32'h0_0000;
  localparam int unsigned DEF_WORD_COUNT = 32'h0_2BBE;

  typedef enum logic [2:0] {
    IDLE,
    LO,
    HI,
    WR,
    FIN
`ifdef DNN_LOADER_CHECKSUM_EN
    ,
    CHK_LO,
    CHK_HI
`endif
  } loader_state_t;

endpackage

// File: rtl/dnn_param_loader_if.sv
// Byte stream in and memory write port out of the parameter loader.
// master = stream source / memory side, slave = the loader.
interface dnn_param_loader_if
  import dnn_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
  logic                     in_valid;
  logic [BYTE_W-1:0]        in_byte;
  logic                     in_ready;
  logic                     wr_en;
  logic [ADDR_WIDTH-1:0]    wr_addr;
  logic signed [WORD_W-1:0] wr_data;

  modport master (
    output in_valid, in_byte,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_byte,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/dnn_param_loader.sv
// Loads little-endian 16-bit parameter words from a byte stream into memory,
// then starts the inference engine. Optional checksum: DNN_LOADER_CHECKSUM_EN.
//
// state  | meaning
// IDLE   | waiting for load_start
// LO     | accepting low byte of a word
// HI     | accepting high byte; word registered on transfer
// WR     | one-cycle memory write, advance address/counter
// CHK_LO | accepting low byte of checksum word (macro only)
// CHK_HI | accepting high byte of checksum word (macro only)
// FIN    | set done, pulse engine_start
module dnn_param_loader
  import dnn_pkg::*;
#(
  parameter int          ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned ADDR_BASE  = DEF_ADDR_BASE,
  parameter int unsigned WORD_COUNT = DEF_WORD_COUNT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_start,
  input  logic                abort,
  dnn_param_loader_if.slave   bus,
  output logic                busy,
  output logic                done,
  output logic                engine_start
`ifdef DNN_LOADER_CHECKSUM_EN
  ,
  output logic                chk_err
`endif
);

  // Counter is one bit wider so a full 2^ADDR_WIDTH load still fits.
  localparam logic [ADDR_WIDTH:0]   LAST_CNT = (ADDR_WIDTH+1)'(WORD_COUNT - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(ADDR_BASE);

  loader_state_t state, state_nxt;

  logic [ADDR_WIDTH:0]      cnt;
  logic [ADDR_WIDTH-1:0]    addr;
  logic [BYTE_W-1:0]        lo_byte;
  logic [ADDR_WIDTH-1:0]    wr_addr_q;
  logic signed [WORD_W-1:0] wr_data_q;
  logic                     done_q;
  logic                     in_ready_c;
  logic                     wr_en_c;
  logic                     busy_c;
  logic                     engine_start_c;
  logic                     xfer;
  logic                     last_word;
  logic                     err_flag;

`ifdef DNN_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] sum;
  logic              chk_err_q;
  assign err_flag = chk_err_q;
  assign chk_err  = chk_err_q;
`else
  assign err_flag = 1'b0;
`endif

  assign xfer      = bus.in_valid && in_ready_c;
  assign last_word = (cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    in_ready_c     = 1'b0;
    wr_en_c        = 1'b0;
    busy_c         = 1'b1;
    engine_start_c = 1'b0;
    case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (load_start) state_nxt = LO;
      end
      LO: begin
        in_ready_c = !abort;
        if (abort)             state_nxt = IDLE;
        else if (bus.in_valid) state_nxt = HI;
      end
      HI: begin
        in_ready_c = !abort;
        if (abort)             state_nxt = IDLE;
        else if (bus.in_valid) state_nxt = WR;
      end
      WR: begin
        wr_en_c = 1'b1;
        if (abort)          state_nxt = IDLE;
`ifdef DNN_LOADER_CHECKSUM_EN
        else if (last_word) state_nxt = CHK_LO;
`else
        else if (last_word) state_nxt = FIN;
`endif
        else                state_nxt = LO;
      end
`ifdef DNN_LOADER_CHECKSUM_EN
      CHK_LO: begin
        in_ready_c = !abort;
        if (abort)             state_nxt = IDLE;
        else if (bus.in_valid) state_nxt = CHK_HI;
      end
      CHK_HI: begin
        in_ready_c = !abort;
        if (abort)             state_nxt = IDLE;
        else if (bus.in_valid) state_nxt = FIN;
      end
`endif
      FIN: begin
        engine_start_c = !abort && !err_flag;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      addr      <= '0;
      lo_byte   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
`ifdef DNN_LOADER_CHECKSUM_EN
      sum       <= '0;
      chk_err_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (load_start) begin
            cnt    <= '0;
            addr   <= BASE;
            done_q <= 1'b0;
`ifdef DNN_LOADER_CHECKSUM_EN
            sum       <= '0;
            chk_err_q <= 1'b0;
`endif
          end
        end
        LO: if (xfer) lo_byte <= bus.in_byte;
        HI: begin
          if (xfer) begin
            wr_data_q <= $signed({bus.in_byte, lo_byte});
            wr_addr_q <= addr;
          end
        end
        WR: begin
          addr <= addr + 1'b1;
          cnt  <= cnt + 1'b1;
`ifdef DNN_LOADER_CHECKSUM_EN
          sum  <= sum + $unsigned(wr_data_q);
`endif
        end
`ifdef DNN_LOADER_CHECKSUM_EN
        CHK_LO: if (xfer) lo_byte <= bus.in_byte;
        CHK_HI: if (xfer) chk_err_q <= ({bus.in_byte, lo_byte} != sum);
`endif
        FIN: if (!abort) done_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.in_ready = in_ready_c;
  assign bus.wr_en    = wr_en_c;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign busy         = busy_c;
  assign done         = done_q;
  assign engine_start = engine_start_c;

endmodule

// File: tb/tb_dnn_param_loader.sv
// Directed bench for dnn_param_loader with WORD_COUNT=3, ADDR_BASE=0.
// Checksum scenarios run when DNN_LOADER_CHECKSUM_EN is defined.
module tb_dnn_param_loader;
  import dnn_pkg::*;

  localparam int AW = 17;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic load_start = 1'b0;
  logic abort = 1'b0;
  logic busy, done, engine_start;
`ifdef DNN_LOADER_CHECKSUM_EN
  logic chk_err;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int es_cnt = 0;
  logic [AW-1:0] log_addr[$];
  logic [15:0]   log_data[$];

  dnn_param_loader_if #(.ADDR_WIDTH(AW)) bus ();

  dnn_param_loader #(
    .ADDR_WIDTH(AW),
    .ADDR_BASE (0),
    .WORD_COUNT(3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .abort       (abort),
    .bus         (bus.slave),
    .busy        (busy),
    .done        (done),
    .engine_start(engine_start)
`ifdef DNN_LOADER_CHECKSUM_EN
    ,
    .chk_err     (chk_err)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      log_addr.push_back(bus.wr_addr);
      log_data.push_back({bus.wr_data});
    end
    if (engine_start === 1'b1) es_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    log_addr.delete();
    log_data.delete();
    es_cnt = 0;
  endtask

  task automatic pulse_load();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    bit sent = 1'b0;
    int guard = 0;
    bus.in_byte = b;
    while (!sent && guard < 50) begin
      bus.in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      sent = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      guard++;
    end
    bus.in_valid = 1'b0;
    if (!sent) check("byte_timeout", 32'(sent), 32'h1);
  endtask

  task automatic send_word(input logic [15:0] w, input bit rnd);
    send_byte(w[7:0], rnd);
    send_byte(w[15:8], rnd);
  endtask

  task automatic send_std(input bit rnd);
    send_word(16'h1234, rnd);
    send_word(16'h5678, rnd);
    send_word(16'h9ABC, rnd);
`ifdef DNN_LOADER_CHECKSUM_EN
    send_word(16'h0368, rnd);
`endif
  endtask

  task automatic wait_done(input string tag);
    int guard = 0;
    @(negedge clk);
    while (done !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check(tag, 32'(done), 32'h1);
    @(posedge clk); #1;
  endtask

  task automatic check_std(input string tag);
    logic [15:0] exp_data [3];
    exp_data[0] = 16'h1234;
    exp_data[1] = 16'h5678;
    exp_data[2] = 16'h9ABC;
    check({tag, "_nwr"}, 32'(log_addr.size()), 32'd3);
    for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 32'(log_addr[i]), 32'(i));
      check($sformatf("%s_data%0d", tag, i), 32'(log_data[i]), 32'(exp_data[i]));
    end
    check({tag, "_es"}, 32'(es_cnt), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;

    // reset state
    #2;
    check("rst_in_ready", 32'(bus.in_ready), 32'h0);
    check("rst_wr_en", 32'(bus.wr_en), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_es", 32'(engine_start), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // straight load, in_valid always high
    clear_logs();
    pulse_load();
    check("ld_busy", 32'(busy), 32'h1);
    check("ld_ready", 32'(bus.in_ready), 32'h1);
    send_std(1'b0);
    wait_done("basic_done");
    check_std("basic");

    // random in_valid
    clear_logs();
    pulse_load();
    check("rnd_done_clr", 32'(done), 32'h0);
    send_std(1'b1);
    wait_done("rnd_done");
    check_std("rnd");

    // load_start while busy is ignored
    clear_logs();
    pulse_load();
    send_word(16'h1234, 1'b0);
    pulse_load();
    send_byte(8'h78, 1'b0);
    pulse_load();
    send_byte(8'h56, 1'b0);
    send_word(16'h9ABC, 1'b0);
`ifdef DNN_LOADER_CHECKSUM_EN
    send_word(16'h0368, 1'b0);
`endif
    wait_done("busy_ls_done");
    check_std("busy_ls");

    // abort after the low byte of word 2
    clear_logs();
    pulse_load();
    send_word(16'h1234, 1'b0);
    send_byte(8'h78, 1'b0);
    bus.in_byte  = 8'h56;
    bus.in_valid = 1'b1;
    abort        = 1'b1;
    @(negedge clk);
    check("abort_ready", 32'(bus.in_ready), 32'h0);
    @(posedge clk); #1;
    abort        = 1'b0;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort_nwr", 32'(log_addr.size()), 32'd1);
    check("abort_done", 32'(done), 32'h0);
    check("abort_es", 32'(es_cnt), 32'd0);
    check("abort_busy", 32'(busy), 32'h0);
    clear_logs();
    pulse_load();
    send_std(1'b0);
    wait_done("post_abort_done");
    check_std("post_abort");

    // async reset during HI
    clear_logs();
    pulse_load();
    send_byte(8'h34, 1'b0);
    bus.in_byte  = 8'h12;
    bus.in_valid = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("arst_ready", 32'(bus.in_ready), 32'h0);
    check("arst_wr_en", 32'(bus.wr_en), 32'h0);
    check("arst_addr", 32'(bus.wr_addr), 32'h0);
    check("arst_data", {16'h0, bus.wr_data}, 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_done", 32'(done), 32'h0);
    check("arst_es", 32'(engine_start), 32'h0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("arst_nwr", 32'(log_addr.size()), 32'd0);
    pulse_load();
    send_std(1'b0);
    wait_done("post_rst_done");
    check_std("post_rst");

`ifdef DNN_LOADER_CHECKSUM_EN
    // 0001 + FFFF + 0000 = 0000
    clear_logs();
    pulse_load();
    send_word(16'h0001, 1'b0);
    send_word(16'hFFFF, 1'b0);
    send_word(16'h0000, 1'b0);
    send_word(16'h0000, 1'b0);
    wait_done("chk_ok_done");
    check("chk_ok_err", 32'(chk_err), 32'h0);
    check("chk_ok_es", 32'(es_cnt), 32'd1);
    check("chk_ok_nwr", 32'(log_addr.size()), 32'd3);

    clear_logs();
    pulse_load();
    send_word(16'h0001, 1'b0);
    send_word(16'hFFFF, 1'b0);
    send_word(16'h0000, 1'b0);
    send_word(16'h0001, 1'b0);
    wait_done("chk_bad_done");
    check("chk_bad_err", 32'(chk_err), 32'h1);
    check("chk_bad_es", 32'(es_cnt), 32'd0);
    check("chk_bad_nwr", 32'(log_addr.size()), 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dnn_param_loader.md
DNN_PARAM_LOADER -- requirements
Module: dnn_param_loader

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 17: width of the parameter-memory address.
REQ-002 The block SHALL have parameter ADDR_BASE, default 17'h00000: first memory word written.
REQ-003 The block SHALL have parameter WORD_COUNT, default 17'h02BBE: number of 16-bit words per load, range 1..2^ADDR_WIDTH-ADDR_BASE.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port load_start, input, 1 bit: one-cycle request to begin a load.
REQ-007 The block SHALL have port abort, input, 1 bit: synchronous cancel of a load in progress.
REQ-008 The block SHALL have ports in_valid (input, 1), in_byte (input, 8) and in_ready (output, 1): the byte stream, transferred when in_valid and in_ready are both high.
REQ-009 The block SHALL have ports wr_en (output, 1), wr_addr (output, ADDR_WIDTH) and wr_data (output, 16, signed): the write port into the memory that the inference engine reads.
REQ-010 The block SHALL have ports busy (output, 1), done (output, 1) and engine_start (output, 1): status outputs and the start pulse to the inference engine.
REQ-011 The block SHALL have port chk_err (output, 1), which exists only under the macro in REQ-027.

Function
REQ-012 The FSM SHALL have states IDLE, LO, HI, WR, FIN, plus CHK_LO and CHK_HI when the REQ-027 macro is defined.
REQ-013 In IDLE, load_start SHALL clear the word counter, set the address to ADDR_BASE, clear done and move to LO.
REQ-014 in_ready SHALL be 1 only in LO, HI, CHK_LO and CHK_HI, and only while abort is 0.
REQ-015 Byte order SHALL be little-endian: the LO-state byte is wr_data[7:0] and the HI-state byte is wr_data[15:8].
REQ-016 A transfer in HI SHALL register wr_data and wr_addr and move to WR.
REQ-017 In WR, wr_en SHALL be 1 for exactly one cycle; this is the cycle after the HI transfer.
REQ-018 In WR, the address and word counter SHALL then increment.
REQ-019 From WR the FSM SHALL go to LO if words remain, otherwise to FIN, or to CHK_LO with the macro.
REQ-020 The maximum rate SHALL be one word per 3 cycles; no skid buffer is required.
REQ-021 Addresses SHALL be strictly sequential from ADDR_BASE to ADDR_BASE+WORD_COUNT-1, with no wrap; the last word is written at exactly that address.
REQ-022 FIN SHALL last one cycle: done is set and held until the next load_start; engine_start pulses for one cycle unless chk_err is 1; then the FSM returns to IDLE.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 load_start SHALL be ignored when busy is 1.
REQ-025 abort while busy SHALL return the FSM to IDLE on the next edge: no byte is consumed that cycle, no wr_en, no done and no engine_start; a WR-state write already presented still completes.
REQ-026 If abort and load_start are both high in IDLE, load_start SHALL win.

Configuration
REQ-027 Macro DNN_LOADER_CHECKSUM_EN: when defined, the block SHALL keep a 16-bit modulo sum of all written words.
REQ-028 With DNN_LOADER_CHECKSUM_EN, after the last word one further little-endian word SHALL be received (CHK_LO, CHK_HI) and never written to memory.
REQ-029 With DNN_LOADER_CHECKSUM_EN, chk_err SHALL be set in FIN if the received word differs from the sum; it holds until the next load_start, and when set engine_start is suppressed.
REQ-030 Without DNN_LOADER_CHECKSUM_EN, the chk_err port, the checksum states and the checksum logic SHALL be absent, and FIN follows the last WR directly.

Reset
REQ-031 While rst is 0, the block SHALL hold state IDLE, counter and address at 0, and all outputs at 0 (in_ready, wr_en, wr_addr, wr_data, busy, done, engine_start, chk_err).
REQ-032 An assertion of rst mid-load SHALL discard the partial word, and no wr_en SHALL occur after reset is applied.
REQ-033 Release of rst SHALL take effect on the first clk edge after rst returns to 1.

Structure
REQ-034 Package dnn_pkg SHALL hold the FSM state enum (loader_state_t), the byte/word width constants and the default ADDR_BASE/WORD_COUNT values shared with the inference engine's memory map.
REQ-035 The block SHALL be a single module with no sub-module; the checksum is inline logic under the macro.

Verification
REQ-036 With WORD_COUNT=3, bytes 34 12 78 56 BC 9A and in_valid always 1: wr_en SHALL pulse 3 times with (addr 0, 1234), (1, 5678), (2, 9ABC), then done=1 and one engine_start.
REQ-037 With in_valid toggling randomly: the written data and addresses SHALL match REQ-036 and no byte SHALL be lost or duplicated.
REQ-038 With abort asserted after the LO byte of word 2: no second wr_en, done and engine_start stay 0, and a new load_start restarts at ADDR_BASE.
REQ-039 With rst pulsed low during HI: all outputs SHALL read 0 immediately (asynchronously), and the next load SHALL write from ADDR_BASE.
REQ-040 Under DNN_LOADER_CHECKSUM_EN, with words 0001 and FFFF and checksum 0000: chk_err=0 and engine_start pulses; with checksum 0001: chk_err=1 and no engine_start.
REQ-041 With load_start pulsed while busy: no effect, and the sequence of addresses is unchanged.
